register_file_16: RTL and testbench

REGISTER_FILE_16 -- requirements
Module: register_file_16

---
 rtl/register_file_16_pkg.sv | 14 +
 rtl/decoder_4_16.sv | 15 +
 rtl/mux_16_1.sv | 14 +
 rtl/register_file_16.sv | 81 ++++++++
 tb/tb_register_file_16.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/register_file_16_pkg.sv
// Shared CPU constants for the register file: register count, address width and
// the special register indices.
package register_file_16_pkg;

  localparam int unsigned NumRegs = 15;
  localparam int unsigned AddrW   = 4;
  localparam int unsigned NumSel  = 16;

  typedef logic [AddrW-1:0] reg_addr_t;

  localparam reg_addr_t LR_IDX = 4'd14;
  localparam reg_addr_t PC_IDX = 4'd15;

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when en is low.
module decoder_4_16
  import register_file_16_pkg::*;
(
  input  logic              en,
  input  reg_addr_t         addr,
  output logic [NumSel-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end

endmodule

// File: rtl/mux_16_1.sv
// 16:1 selector cell, W bits wide.
module mux_16_1
  import register_file_16_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [NumSel-1:0][W-1:0] data,
  input  reg_addr_t                sel,
  output logic [W-1:0]             y
);

  assign y = data[sel];

endmodule

// File: rtl/register_file_16.sv
// 15-entry register file (R0..R14) with two read ports, one debug read port,
// a main write port and a link write port to R14. Address 15 reads the PC input.
module register_file_16
  import register_file_16_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  reg_addr_t     ra1,
  input  reg_addr_t     ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  reg_addr_t     wa3,
  input  logic [W-1:0]  wd3,
  input  logic          we3,
  input  logic          link_we,
  input  logic [W-1:0]  link_wd,
  input  logic [W-1:0]  r15,
  input  reg_addr_t     dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0]              regs_q [NumRegs];
  logic [NumSel-1:0]         main_we;
  logic [NumSel-1:0][W-1:0]  sel_in;
  logic                      unused_pc_we;

  decoder_4_16 u_dec (
    .en     (we3),
    .addr   (wa3),
    .onehot (main_we)
  );

  // PC writes are handled by the fetch stage, so the decoded enable is dropped.
  assign unused_pc_we = main_we[PC_IDX];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (main_we[i]) begin
          regs_q[i] <= wd3;
        end
      end
      // Main port has priority over the link port on R14.
      if (link_we && !main_we[LR_IDX]) begin
        regs_q[LR_IDX] <= link_wd;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      sel_in[i] = regs_q[i];
    end
    sel_in[PC_IDX] = r15;
  end

  mux_16_1 #(.W(W)) u_mux_rd1 (
    .data (sel_in),
    .sel  (ra1),
    .y    (rd1)
  );

  mux_16_1 #(.W(W)) u_mux_rd2 (
    .data (sel_in),
    .sel  (ra2),
    .y    (rd2)
  );

  mux_16_1 #(.W(W)) u_mux_dbg (
    .data (sel_in),
    .sel  (dbg_addr),
    .y    (dbg_data)
  );

endmodule

// File: tb/tb_register_file_16.sv
// Directed and random checks of register_file_16 against a bench-side register model,
// with expected values queued in a scoreboard at drive time.
module tb_register_file_16;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   ra1, ra2, wa3, dbg_addr;
  logic [W-1:0] rd1, rd2, dbg_data;
  logic [W-1:0] wd3, link_wd, r15;
  logic         we3, link_we;

  logic [W-1:0] model [15];
  logic [W-1:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;

  register_file_16 #(.W(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .wa3      (wa3),
    .wd3      (wd3),
    .we3      (we3),
    .link_we  (link_we),
    .link_wd  (link_wd),
    .r15      (r15),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rd(input logic [3:0] a);
    return (a == 4'd15) ? r15 : model[a];
  endfunction

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 15; i++) model[i] = '0;
  endtask

  // Advance one rising edge and apply the inputs that were present at it to the model.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      if (link_we) model[14] = link_wd;
      if (we3 && wa3 != 4'd15) model[wa3] = wd3;
    end
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    ra1 = '0; ra2 = '0; wa3 = '0; dbg_addr = '0;
    wd3 = '0; link_wd = '0; we3 = 1'b0; link_we = 1'b0;
    r15 = 32'h0000_0108;
    clear_model();

    // Reads while held in reset
    #2;
    ra1 = 4'd3; ra2 = 4'd15;
    #1;
    push(32'h0); check("rst_rd1_r3", rd1);
    push(32'h0000_0108); check("rst_rd2_r15", rd2);

    tick();
    tick();
    reset_n = 1'b1;

    // All registers zero after reset, address 15 returns r15
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i);
      #1;
      push(32'h0); check("post_rst_rd1", rd1);
    end
    ra1 = 4'd15;
    #1;
    push(32'h0000_0108); check("post_rst_rd1_pc", rd1);

    // Write R3, no bypass before the edge
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEAD_BEEF; ra1 = 4'd3;
    #1;
    push(32'h0); check("r3_pre_edge", rd1);
    tick();
    push(32'hDEAD_BEEF); check("r3_post_edge", rd1);

    // Write to address 15 is ignored
    wa3 = 4'd15; wd3 = 32'h1234_5678; r15 = 32'h0000_0200; ra2 = 4'd15;
    tick();
    we3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1;
      push(ref_rd(4'(i))); check("pc_write_ignored", dbg_data);
    end
    push(32'h0000_0200); check("rd2_r15", rd2);

    // Main and link collide on R14: main wins
    we3 = 1'b1; wa3 = 4'd14; wd3 = 32'hAAAA_0000;
    link_we = 1'b1; link_wd = 32'h0000_0040;
    tick();
    we3 = 1'b0; link_we = 1'b0; ra1 = 4'd14;
    #1;
    push(32'hAAAA_0000); check("r14_main_wins", rd1);

    // Main to R2 and link to R14 on the same edge
    we3 = 1'b1; wa3 = 4'd2; link_we = 1'b1;
    tick();
    we3 = 1'b0; link_we = 1'b0; ra1 = 4'd2; ra2 = 4'd14;
    #1;
    push(32'hAAAA_0000); check("dual_r2", rd1);
    push(32'h0000_0040); check("dual_r14", rd2);

    // Fill every register with its index
    we3 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wa3 = 4'(i); wd3 = W'(i);
      tick();
    end
    we3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1;
      push(W'(i)); check("fill_idx", dbg_data);
    end

    // Async reset between edges clears everything at once
    ra1 = 4'd1; ra2 = 4'd7; dbg_addr = 4'd14;
    tick();
    reset_n = 1'b0;
    clear_model();
    #1;
    push(32'h0); check("async_rst_rd1", rd1);
    push(32'h0); check("async_rst_rd2", rd2);
    push(32'h0); check("async_rst_dbg", dbg_data);
    // Writes presented during reset, across an edge, are dropped
    we3 = 1'b1; wa3 = 4'd9; wd3 = 32'hFFFF_FFFF;
    tick();
    we3 = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1;
      push(32'h0); check("after_pulse", dbg_data);
    end

    // Reset asserted mid-write leaves the target at zero
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h5555_5555;
    #1;
    reset_n = 1'b0;
    clear_model();
    tick();
    we3 = 1'b0;
    reset_n = 1'b1;
    dbg_addr = 4'd5;
    #1;
    push(32'h0); check("mid_write_rst", dbg_data);

    // Random traffic on all ports
    for (int n = 0; n < 10000; n++) begin
      we3      = 1'($urandom_range(0, 1));
      link_we  = ($urandom_range(0, 3) == 0);
      wa3      = 4'($urandom_range(0, 15));
      wd3      = $urandom;
      link_wd  = $urandom;
      r15      = $urandom;
      ra1      = 4'($urandom_range(0, 15));
      ra2      = 4'($urandom_range(0, 15));
      dbg_addr = 4'($urandom_range(0, 15));
      #1;
      push(ref_rd(ra1));      check("rand_rd1", rd1);
      push(ref_rd(ra2));      check("rand_rd2", rd2);
      push(ref_rd(dbg_addr)); check("rand_dbg", dbg_data);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
